// File: rtl/rs_age_issue_queue.sv
// Age-ordered reservation station: CDB wakeup, oldest-first multi-FU select,
// registered issue, alloc backpressure, flush and occupancy.
module rs_age_issue_queue #(
  parameter int ENTRIES   = 8,
  parameter int FU_NUM    = 2,
  parameter int CDB_PORTS = 2,
  parameter int PREG_W    = 7,
  parameter int VAL_W     = 32,
  parameter int TAG_W     = 5,
  parameter int CTRL_W    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [CTRL_W-1:0]              alloc_ctrl,
  input  logic [TAG_W-1:0]               alloc_tag,
  input  logic [PREG_W-1:0]              alloc_dst,
  input  logic [PREG_W-1:0]              alloc_src1_addr,
  input  logic [PREG_W-1:0]              alloc_src2_addr,
  input  logic [VAL_W-1:0]               alloc_src1_val,
  input  logic [VAL_W-1:0]               alloc_src2_val,
  input  logic                           alloc_src1_rdy,
  input  logic                           alloc_src2_rdy,
  input  logic [VAL_W-1:0]               alloc_imm,
  input  logic [VAL_W-1:0]               alloc_pc,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS*PREG_W-1:0]    cdb_addr,
  input  logic [CDB_PORTS*VAL_W-1:0]     cdb_val,
  input  logic [FU_NUM-1:0]              fu_ready,
  input  logic                           flush,
  output logic [FU_NUM-1:0]              issue_valid,
  output logic [FU_NUM*CTRL_W-1:0]       issue_ctrl,
  output logic [FU_NUM*TAG_W-1:0]        issue_tag,
  output logic [FU_NUM*PREG_W-1:0]       issue_dst,
  output logic [FU_NUM*VAL_W-1:0]        issue_src1_val,
  output logic [FU_NUM*VAL_W-1:0]        issue_src2_val,
  output logic [FU_NUM*VAL_W-1:0]        issue_imm,
  output logic [FU_NUM*VAL_W-1:0]        issue_pc,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);
  localparam int OCC_W = $clog2(ENTRIES+1);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [OCC_W-1:0] ONE_OCC = OCC_W'(1);

  // Returns {hit, value}; ports are scanned high to low so the lowest port wins.
  function automatic logic [VAL_W:0] cdb_lookup(
    input logic [PREG_W-1:0]           addr,
    input logic [CDB_PORTS-1:0]        c_valid,
    input logic [CDB_PORTS*PREG_W-1:0] c_addr,
    input logic [CDB_PORTS*VAL_W-1:0]  c_val
  );
    logic [VAL_W:0] res;
    res = '0;
    for (int k = CDB_PORTS-1; k >= 0; k--) begin
      if (c_valid[k] && (c_addr[k*PREG_W +: PREG_W] == addr)) res = {1'b1, c_val[k*VAL_W +: VAL_W]};
      else res = res;
    end
    return res;
  endfunction

  logic [ENTRIES-1:0] valid_r, src1_rdy_r, src2_rdy_r;
  logic [CTRL_W-1:0]  ctrl_r      [ENTRIES];
  logic [TAG_W-1:0]   tag_r       [ENTRIES];
  logic [PREG_W-1:0]  dst_r       [ENTRIES];
  logic [PREG_W-1:0]  src1_addr_r [ENTRIES];
  logic [PREG_W-1:0]  src2_addr_r [ENTRIES];
  logic [VAL_W-1:0]   src1_val_r  [ENTRIES];
  logic [VAL_W-1:0]   src2_val_r  [ENTRIES];
  logic [VAL_W-1:0]   imm_r       [ENTRIES];
  logic [VAL_W-1:0]   pc_r        [ENTRIES];
  logic [ENTRIES-1:0] age_r       [ENTRIES];   // age_r[i][j]: entry i is older than entry j
  logic [OCC_W-1:0]   occ_r;

  logic [FU_NUM-1:0]        issue_valid_r;
  logic [FU_NUM*CTRL_W-1:0] issue_ctrl_r;
  logic [FU_NUM*TAG_W-1:0]  issue_tag_r;
  logic [FU_NUM*PREG_W-1:0] issue_dst_r;
  logic [FU_NUM*VAL_W-1:0]  issue_src1_val_r, issue_src2_val_r, issue_imm_r, issue_pc_r;

  logic                alloc_fire_s;
  logic [IDX_W-1:0]    alloc_idx_s;
  logic [VAL_W:0]      al1_s, al2_s;
  logic [VAL_W:0]      wk1_s [ENTRIES];
  logic [VAL_W:0]      wk2_s [ENTRIES];
  logic [ENTRIES-1:0]  elig_s, issued_s;
  logic [OCC_W-1:0]    rank_s [ENTRIES];
  logic [FU_NUM-1:0]   sel_vld_s;
  logic [IDX_W-1:0]    sel_idx_s [FU_NUM];
  logic [OCC_W-1:0]    slot_s, issue_cnt_s, occ_nxt_s;

  assign alloc_ready  = (occ_r < OCC_W'(ENTRIES));
  assign alloc_fire_s = alloc_valid && alloc_ready;

  // Free-slot search, CDB lookups for the allocating and resident operands.
  always_comb begin
    alloc_idx_s = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (!valid_r[i]) alloc_idx_s = IDX_W'(i);
      else alloc_idx_s = alloc_idx_s;
    end
    al1_s = cdb_lookup(alloc_src1_addr, cdb_valid, cdb_addr, cdb_val);
    al2_s = cdb_lookup(alloc_src2_addr, cdb_valid, cdb_addr, cdb_val);
    for (int i = 0; i < ENTRIES; i++) begin
      wk1_s[i] = cdb_lookup(src1_addr_r[i], cdb_valid, cdb_addr, cdb_val);
      wk2_s[i] = cdb_lookup(src2_addr_r[i], cdb_valid, cdb_addr, cdb_val);
    end
  end

  // Oldest-first selection: an entry's rank is the number of older eligible entries.
  always_comb begin
    elig_s      = valid_r & src1_rdy_r & src2_rdy_r;
    issued_s    = '0;
    sel_vld_s   = '0;
    slot_s      = '0;
    issue_cnt_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      rank_s[i] = '0;
      for (int j = 0; j < ENTRIES; j++)
        rank_s[i] = rank_s[i] + ((elig_s[j] && age_r[j][i]) ? ONE_OCC : '0);
    end
    for (int k = 0; k < FU_NUM; k++) begin
      sel_idx_s[k] = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (fu_ready[k] && elig_s[i] && (rank_s[i] == slot_s)) begin
          sel_vld_s[k] = 1'b1;
          sel_idx_s[k] = IDX_W'(i);
          issued_s[i]  = 1'b1;
        end else begin
          sel_vld_s[k] = sel_vld_s[k];
        end
      end
      slot_s      = slot_s + (fu_ready[k] ? ONE_OCC : '0);
      issue_cnt_s = issue_cnt_s + (sel_vld_s[k] ? ONE_OCC : '0);
    end
    occ_nxt_s = occ_r + {{(OCC_W-1){1'b0}}, alloc_fire_s} - issue_cnt_s;
  end

  // Entry storage, age matrix, wakeup, issue registers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r          <= '0;
      src1_rdy_r       <= '0;
      src2_rdy_r       <= '0;
      occ_r            <= '0;
      issue_valid_r    <= '0;
      issue_ctrl_r     <= '0;
      issue_tag_r      <= '0;
      issue_dst_r      <= '0;
      issue_src1_val_r <= '0;
      issue_src2_val_r <= '0;
      issue_imm_r      <= '0;
      issue_pc_r       <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctrl_r[i]      <= '0;
        tag_r[i]       <= '0;
        dst_r[i]       <= '0;
        src1_addr_r[i] <= '0;
        src2_addr_r[i] <= '0;
        src1_val_r[i]  <= '0;
        src2_val_r[i]  <= '0;
        imm_r[i]       <= '0;
        pc_r[i]        <= '0;
        age_r[i]       <= '0;
      end
    end else if (flush) begin
      valid_r       <= '0;
      occ_r         <= '0;
      issue_valid_r <= '0;
    end else begin
      issue_valid_r <= sel_vld_s;
      for (int k = 0; k < FU_NUM; k++) begin
        if (sel_vld_s[k]) begin
          issue_ctrl_r[k*CTRL_W +: CTRL_W]    <= ctrl_r[sel_idx_s[k]];
          issue_tag_r[k*TAG_W +: TAG_W]       <= tag_r[sel_idx_s[k]];
          issue_dst_r[k*PREG_W +: PREG_W]     <= dst_r[sel_idx_s[k]];
          issue_src1_val_r[k*VAL_W +: VAL_W]  <= src1_val_r[sel_idx_s[k]];
          issue_src2_val_r[k*VAL_W +: VAL_W]  <= src2_val_r[sel_idx_s[k]];
          issue_imm_r[k*VAL_W +: VAL_W]       <= imm_r[sel_idx_s[k]];
          issue_pc_r[k*VAL_W +: VAL_W]        <= pc_r[sel_idx_s[k]];
        end
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (issued_s[i]) valid_r[i] <= 1'b0;
        if (valid_r[i] && !src1_rdy_r[i] && wk1_s[i][VAL_W]) begin
          src1_rdy_r[i] <= 1'b1;
          src1_val_r[i] <= wk1_s[i][VAL_W-1:0];
        end
        if (valid_r[i] && !src2_rdy_r[i] && wk2_s[i][VAL_W]) begin
          src2_rdy_r[i] <= 1'b1;
          src2_val_r[i] <= wk2_s[i][VAL_W-1:0];
        end
      end
      if (alloc_fire_s) begin
        valid_r[alloc_idx_s]     <= 1'b1;
        ctrl_r[alloc_idx_s]      <= alloc_ctrl;
        tag_r[alloc_idx_s]       <= alloc_tag;
        dst_r[alloc_idx_s]       <= alloc_dst;
        src1_addr_r[alloc_idx_s] <= alloc_src1_addr;
        src2_addr_r[alloc_idx_s] <= alloc_src2_addr;
        src1_rdy_r[alloc_idx_s]  <= al1_s[VAL_W] | alloc_src1_rdy;
        src2_rdy_r[alloc_idx_s]  <= al2_s[VAL_W] | alloc_src2_rdy;
        src1_val_r[alloc_idx_s]  <= al1_s[VAL_W] ? al1_s[VAL_W-1:0] : alloc_src1_val;
        src2_val_r[alloc_idx_s]  <= al2_s[VAL_W] ? al2_s[VAL_W-1:0] : alloc_src2_val;
        imm_r[alloc_idx_s]       <= alloc_imm;
        pc_r[alloc_idx_s]        <= alloc_pc;
        // New entry is younger than all others: clear its row, set its column.
        age_r[alloc_idx_s]       <= '0;
        for (int j = 0; j < ENTRIES; j++)
          if (IDX_W'(j) != alloc_idx_s) age_r[j][alloc_idx_s] <= 1'b1;
      end
      occ_r <= occ_nxt_s;
    end
  end

  assign issue_valid    = issue_valid_r;
  assign issue_ctrl     = issue_ctrl_r;
  assign issue_tag      = issue_tag_r;
  assign issue_dst      = issue_dst_r;
  assign issue_src1_val = issue_src1_val_r;
  assign issue_src2_val = issue_src2_val_r;
  assign issue_imm      = issue_imm_r;
  assign issue_pc       = issue_pc_r;
  assign occupancy      = occ_r;
endmodule

// File: doc/rs_age_issue_queue.md
Name: rs_age_issue_queue

Overview:
- Parametrised reservation station for the out-of-order core. Sits between rename/dispatch and the functional units.
- Tracks a per-entry ready bit for each operand, wakes operands from a multi-port CDB, and issues up to FU_NUM instructions per cycle in strict oldest-first order.
- Adds alloc backpressure, full flush and occupancy reporting on top of the single-issue, always-accepting station.

Parameters:
- ENTRIES, 8, number of RS entries (>=2).
- FU_NUM, 2, number of FU issue slots.
- CDB_PORTS, 2, number of CDB broadcast ports.
- PREG_W, 7, physical register address width.
- VAL_W, 32, operand, immediate and pc width.
- TAG_W, 5, ROB tag width.
- CTRL_W, 16, packed control word width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- alloc_valid  in  1  new instruction offered.
- alloc_ready  out  1  free entry available.
- alloc_ctrl  in  CTRL_W  control word.
- alloc_tag  in  TAG_W  ROB tag.
- alloc_dst  in  PREG_W  destination preg.
- alloc_src1_addr, alloc_src2_addr  in  PREG_W  source pregs.
- alloc_src1_val, alloc_src2_val  in  VAL_W  register-file values.
- alloc_src1_rdy, alloc_src2_rdy  in  1  value already valid.
- alloc_imm, alloc_pc  in  VAL_W  immediate and pc.
- cdb_valid  in  CDB_PORTS  broadcast valid per port.
- cdb_addr  in  CDB_PORTS*PREG_W  broadcast preg, port k at bits [k*PREG_W +: PREG_W].
- cdb_val  in  CDB_PORTS*VAL_W  broadcast value, same packing.
- fu_ready  in  FU_NUM  FU k can accept this cycle.
- flush  in  1  discard all entries.
- issue_valid  out  FU_NUM  one-cycle issue pulse per FU.
- issue_ctrl, issue_tag, issue_dst, issue_src1_val, issue_src2_val, issue_imm, issue_pc  out  FU_NUM*field width  issued payload, packed per FU like cdb.
- occupancy  out  $clog2(ENTRIES+1)  number of valid entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - All entries invalid.
  - issue_valid=0 and all issue payload=0.
  - occupancy=0; alloc_ready=1 once reset releases.
  - Age state cleared.
- alloc_ready = (occupancy < ENTRIES). It is combinational and does not credit same-cycle frees.
- Allocation on alloc_valid&&alloc_ready at a posedge:
  - Writes the lowest-index free entry.
  - That entry is marked younger than every valid entry. Age is kept as an ENTRIES x ENTRIES age matrix.
  - alloc_valid while alloc_ready=0 is ignored; the producer must hold the request.
- Operand ready:
  - srcN_rdy is set from alloc_srcN_rdy.
  - Same-cycle CDB bypass: if any cdb_valid[k] matches alloc_srcN_addr, srcN is captured from the CDB and rdy=1. The lowest k wins on a multi-match.
- Wakeup: each posedge, every valid entry with rdy=0 and a matching cdb_valid/cdb_addr captures cdb_val and sets rdy=1. The lowest port wins on a multi-match. Entries with rdy=1 ignore the CDB.
- Eligibility (combinational): an entry is eligible when valid && src1_rdy && src2_rdy. The decoder drives alloc_src2_rdy=1 when src2 is unused.
- Select (combinational):
  - Rank eligible entries oldest first.
  - Walk FU index 0..FU_NUM-1; each FU with fu_ready=1 takes the next-oldest eligible entry.
  - FUs with fu_ready=0 are skipped and receive nothing.
- Issue (registered):
  - At the posedge after selection, issue_valid[k]=1 for one cycle with the entry payload, and the entry is freed on that same edge.
  - issue_valid[k]=0 otherwise; payload holds its last value.
- Latency: allocated with both operands ready at edge T → issue_valid at edge T+1 at the earliest. A CDB wakeup at edge T → issue at T+1.
- Simultaneous alloc + issue in one cycle: both take effect. A freed entry is not reused until the next cycle.
- occupancy = previous value + alloc - number of issued entries.
- flush=1 at a posedge:
  - All entries invalid; occupancy=0; issue_valid=0.
  - Allocation, CDB and issue in that cycle are dropped.
  - flush has priority over everything except reset.
- Reset mid-operation aborts immediately, including any pending issue.
- Full (occupancy=ENTRIES): alloc_ready=0. Issue continues; alloc_ready rises the cycle after the first free.
- Empty: issue_valid stays 0.

Test Plan:
1. Reset, then alloc tag=3 with both rdy=1, fu_ready=2'b11 → issue_valid=2'b01 one cycle later, issue_tag[0]=3, occupancy goes 1 → 0.
2. Fill 8 entries with src1_rdy=0, src1_addr=10 → alloc_ready=0. Broadcast cdb_addr=10, cdb_val=0xABCD → the two oldest issue on FU0/FU1 with src1_val=0xABCD, the next two the cycle after, and alloc_ready=1 after the first issue.
3. Alloc with src2_addr=12 and rdy=0 in the same cycle as cdb port1 valid addr=12 val=0x55 → the entry is eligible immediately and issues with src2_val=0x55.
4. Tags 1,2,3 allocated not-ready, then woken in the order 3,2,1 simultaneously → issue order tag1 on FU0, tag2 on FU1, tag3 on the next cycle.
5. fu_ready=2'b10 with two eligible entries → only FU1 gets the oldest (issue_valid=2'b10); the younger entry issues later.
6. 5 valid entries, then flush coincident with alloc_valid and a CDB match → occupancy=0, no issue_valid next cycle, the allocation is dropped.
